// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two write ports, x0 fixed at zero,
// post-reset clear sweep and a same-address conflict flag. Define RF_BYPASS_EN for same-cycle read forwarding.
module register_file_mp #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int REG_COUNT      = (1 << REG_ADDR_WIDTH),
  parameter int NUM_RD         = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0]   RA,
  output logic [NUM_RD*REG_DATA_WIDTH-1:0]   RD,
  input  logic                               WE3,
  input  logic [REG_ADDR_WIDTH-1:0]          A3,
  input  logic [REG_DATA_WIDTH-1:0]          WD3,
  input  logic                               WE4,
  input  logic [REG_ADDR_WIDTH-1:0]          A4,
  input  logic [REG_DATA_WIDTH-1:0]          WD4,
  output logic                               busy,
  output logic                               conflict
);

  localparam int AW = REG_ADDR_WIDTH;
  localparam int DW = REG_DATA_WIDTH;
  localparam logic [AW-1:0] LastIdx = AW'(REG_COUNT - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e        state_q;
  logic [AW-1:0] clrIdx_q;
  logic          conflict_q;
  logic          conflict_d;
  logic [DW-1:0] regs_q [1:REG_COUNT-1];
  logic          ready;
  logic          wr3;
  logic          wr4;

  function automatic logic validAddr(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < REG_COUNT);
  endfunction

  assign ready = rst && (state_q == READY);

  // Port 1 wins a same-address collision, so port 0 is suppressed rather than ordered.
  assign wr4        = ready && WE4 && validAddr(A4);
  assign wr3        = ready && WE3 && validAddr(A3) && !(wr4 && (A3 == A4));
  assign conflict_d = ready && WE3 && WE4 && (A3 == A4) && (A3 != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= CLEAR;
      clrIdx_q   <= AW'(1);
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
      if (state_q == CLEAR) begin
        clrIdx_q <= clrIdx_q + AW'(1);
        if (clrIdx_q == LastIdx) begin
          state_q <= READY;
        end
      end
    end
  end

  // Storage has no reset of its own; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (rst && (state_q == CLEAR)) begin
      regs_q[clrIdx_q] <= '0;
    end
    if (wr3) begin
      regs_q[A3] <= WD3;
    end
    if (wr4) begin
      regs_q[A4] <= WD4;
    end
  end

  assign busy     = !rst || (state_q == CLEAR);
  assign conflict = conflict_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : gRead
    logic [AW-1:0] ra;
    logic [DW-1:0] arrVal;
    logic [DW-1:0] rdVal;

    assign ra     = RA[k*AW +: AW];
    assign arrVal = validAddr(ra) ? regs_q[ra] : '0;

`ifdef RF_BYPASS_EN
    always_comb begin
      rdVal = arrVal;
      if (WE4 && (A4 == ra) && (ra != '0)) begin
        rdVal = WD4;
      end else if (WE3 && (A3 == ra) && (ra != '0)) begin
        rdVal = WD3;
      end
    end
`else
    assign rdVal = arrVal;
`endif

    assign RD[k*DW +: DW] = ready ? rdVal : '0;
  end

endmodule
